// File: rtl/rtc_multi_alrm.sv
// Real-time counter core: prescaler, free-running counter, ALRM_NUM exact-match alarms, sticky W1C status.
// Optional timestamp capture is enabled with `define RTC_CAPTURE_EN.
module rtc_multi_alrm #(
    parameter int CNT_WIDTH      = 32,
    parameter int PSCR_WIDTH     = 20,
    parameter int ALRM_NUM       = 4,
    parameter int ALRM_SEL_WIDTH = (ALRM_NUM > 1) ? $clog2(ALRM_NUM) : 1,
`ifdef RTC_CAPTURE_EN
    parameter int ISTA_WIDTH     = ALRM_NUM + 3
`else
    parameter int ISTA_WIDTH     = ALRM_NUM + 2
`endif
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      en_i,
    input  logic                      pscr_wr_i,
    input  logic [PSCR_WIDTH-1:0]     pscr_i,
    input  logic                      cnt_wr_i,
    input  logic [CNT_WIDTH-1:0]      cnt_wdata_i,
    input  logic                      alrm_wr_i,
    input  logic [ALRM_SEL_WIDTH-1:0] alrm_sel_i,
    input  logic [CNT_WIDTH-1:0]      alrm_cmp_i,
    input  logic [CNT_WIDTH-1:0]      alrm_per_i,
    input  logic                      alrm_mode_i,
    input  logic                      alrm_arm_i,
    input  logic [ISTA_WIDTH-1:0]     ie_i,
    input  logic [ISTA_WIDTH-1:0]     ista_clr_i,
`ifdef RTC_CAPTURE_EN
    input  logic                      cap_trg_i,
    output logic [CNT_WIDTH-1:0]      cap_o,
`endif
    output logic                      tick_o,
    output logic [CNT_WIDTH-1:0]      cnt_o,
    output logic [ALRM_NUM-1:0]       alrm_armed_o,
    output logic [ISTA_WIDTH-1:0]     ista_o,
    output logic                      irq_o
);

    localparam int OVF_BIT  = ALRM_NUM;
    localparam int TICK_BIT = ALRM_NUM + 1;

    logic [PSCR_WIDTH-1:0] pscr_q_r;
    logic [PSCR_WIDTH-1:0] psc_cnt_r;
    logic [CNT_WIDTH-1:0]  cnt_r;
    logic [CNT_WIDTH-1:0]  cnt_inc_s;
    logic [CNT_WIDTH-1:0]  cmp_r [ALRM_NUM];
    logic [CNT_WIDTH-1:0]  per_r [ALRM_NUM];
    logic [ALRM_NUM-1:0]   mode_r;
    logic [ALRM_NUM-1:0]   armed_r;
    logic [ALRM_NUM-1:0]   match_s;
    logic [ALRM_NUM-1:0]   alrm_we_s;
    logic [ISTA_WIDTH-1:0] ista_r;
    logic [ISTA_WIDTH-1:0] ista_set_s;
    logic                  tick_s;
    logic                  ovf_s;

    // Any register write to the timebase swallows the tick so no alarm/overflow is evaluated on a load.
    assign tick_s    = en_i & (psc_cnt_r == pscr_q_r) & ~pscr_wr_i & ~cnt_wr_i;
    assign cnt_inc_s = cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    assign ovf_s     = tick_s & (&cnt_r);

    // Per-channel match against the next counter value and write decode.
    always_comb begin
        match_s   = {ALRM_NUM{1'b0}};
        alrm_we_s = {ALRM_NUM{1'b0}};
        for (int k = 0; k < ALRM_NUM; k++) begin
            match_s[k]   = tick_s & armed_r[k] & (cnt_inc_s == cmp_r[k]);
            alrm_we_s[k] = alrm_wr_i & ({1'b0, alrm_sel_i} == (ALRM_SEL_WIDTH+1)'(k));
        end
    end

`ifdef RTC_CAPTURE_EN
    localparam int CAP_BIT = ALRM_NUM + 2;
    logic                 cap_trg_q_r;
    logic                 cap_rise_s;
    logic [CNT_WIDTH-1:0] cap_r;

    assign cap_rise_s = cap_trg_i & ~cap_trg_q_r;

    // Edge detector and capture register; samples the pre-increment counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cap_trg_q_r <= 1'b0;
            cap_r       <= {CNT_WIDTH{1'b0}};
        end else begin
            cap_trg_q_r <= cap_trg_i;
            if (cap_rise_s) begin
                cap_r <= cnt_r;
            end
        end
    end

    assign cap_o = cap_r;
`endif

    // Status set sources for this cycle.
    always_comb begin
        ista_set_s                 = {ISTA_WIDTH{1'b0}};
        ista_set_s[ALRM_NUM-1:0]   = match_s;
        ista_set_s[OVF_BIT]        = ovf_s;
        ista_set_s[TICK_BIT]       = tick_s;
`ifdef RTC_CAPTURE_EN
        ista_set_s[CAP_BIT]        = cap_rise_s;
`endif
    end

    // Prescaler reload register and divider counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pscr_q_r  <= {PSCR_WIDTH{1'b0}};
            psc_cnt_r <= {PSCR_WIDTH{1'b0}};
        end else begin
            if (pscr_wr_i) begin
                pscr_q_r <= pscr_i;
            end
            if (pscr_wr_i || cnt_wr_i || tick_s) begin
                psc_cnt_r <= {PSCR_WIDTH{1'b0}};
            end else if (en_i) begin
                psc_cnt_r <= psc_cnt_r + {{(PSCR_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    // Main counter: load has priority over increment.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (cnt_wr_i) begin
            cnt_r <= cnt_wdata_i;
        end else if (tick_s) begin
            cnt_r <= cnt_inc_s;
        end
    end

    // Alarm channels: a host write overrides the match-driven re-arm on the same channel.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < ALRM_NUM; k++) begin
                cmp_r[k] <= {CNT_WIDTH{1'b0}};
                per_r[k] <= {CNT_WIDTH{1'b0}};
            end
            mode_r  <= {ALRM_NUM{1'b0}};
            armed_r <= {ALRM_NUM{1'b0}};
        end else begin
            for (int k = 0; k < ALRM_NUM; k++) begin
                if (alrm_we_s[k]) begin
                    cmp_r[k]   <= alrm_cmp_i;
                    per_r[k]   <= alrm_per_i;
                    mode_r[k]  <= alrm_mode_i;
                    armed_r[k] <= alrm_arm_i;
                end else if (match_s[k]) begin
                    if (mode_r[k]) begin
                        cmp_r[k] <= cmp_r[k] + per_r[k];
                    end else begin
                        armed_r[k] <= 1'b0;
                    end
                end
            end
        end
    end

    // Sticky status; a set beats a simultaneous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ista_r <= {ISTA_WIDTH{1'b0}};
        end else begin
            ista_r <= (ista_r & ~ista_clr_i) | ista_set_s;
        end
    end

    assign tick_o       = tick_s;
    assign cnt_o        = cnt_r;
    assign alrm_armed_o = armed_r;
    assign ista_o       = ista_r;
    assign irq_o        = |(ista_r & ie_i);

endmodule

// File: tb/tb_rtc_multi_alrm.sv
// Directed self-checking bench for rtc_multi_alrm (default build, 4 alarms, 32-bit counter).
module tb_rtc_multi_alrm;

    localparam int CW  = 32;
    localparam int PW  = 20;
    localparam int AN  = 4;
    localparam int SW  = 2;
`ifdef RTC_CAPTURE_EN
    localparam int IW  = AN + 3;
`else
    localparam int IW  = AN + 2;
`endif
    localparam int OVF = AN;
    localparam int TCK = AN + 1;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          en_i;
    logic          pscr_wr_i;
    logic [PW-1:0] pscr_i;
    logic          cnt_wr_i;
    logic [CW-1:0] cnt_wdata_i;
    logic          alrm_wr_i;
    logic [SW-1:0] alrm_sel_i;
    logic [CW-1:0] alrm_cmp_i;
    logic [CW-1:0] alrm_per_i;
    logic          alrm_mode_i;
    logic          alrm_arm_i;
    logic [IW-1:0] ie_i;
    logic [IW-1:0] ista_clr_i;
    logic          tick_o;
    logic [CW-1:0] cnt_o;
    logic [AN-1:0] alrm_armed_o;
    logic [IW-1:0] ista_o;
    logic          irq_o;
`ifdef RTC_CAPTURE_EN
    logic          cap_trg_i;
    logic [CW-1:0] cap_o;
`endif

    int checks   = 0;
    int failures = 0;

    rtc_multi_alrm #(.CNT_WIDTH(CW), .PSCR_WIDTH(PW), .ALRM_NUM(AN)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
        .pscr_wr_i(pscr_wr_i), .pscr_i(pscr_i),
        .cnt_wr_i(cnt_wr_i), .cnt_wdata_i(cnt_wdata_i),
        .alrm_wr_i(alrm_wr_i), .alrm_sel_i(alrm_sel_i), .alrm_cmp_i(alrm_cmp_i),
        .alrm_per_i(alrm_per_i), .alrm_mode_i(alrm_mode_i), .alrm_arm_i(alrm_arm_i),
        .ie_i(ie_i), .ista_clr_i(ista_clr_i),
`ifdef RTC_CAPTURE_EN
        .cap_trg_i(cap_trg_i), .cap_o(cap_o),
`endif
        .tick_o(tick_o), .cnt_o(cnt_o), .alrm_armed_o(alrm_armed_o),
        .ista_o(ista_o), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic clk1();
        @(posedge clk_i);
        #1;
    endtask

    task automatic alrm_write(input int sel, input int cmp, input int per, input logic mode, input logic arm);
        alrm_wr_i   = 1'b1;
        alrm_sel_i  = SW'(sel);
        alrm_cmp_i  = CW'(cmp);
        alrm_per_i  = CW'(per);
        alrm_mode_i = mode;
        alrm_arm_i  = arm;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; en_i = 1'b0; pscr_wr_i = 1'b0; pscr_i = '0; cnt_wr_i = 1'b0; cnt_wdata_i = '0;
        alrm_wr_i = 1'b0; alrm_sel_i = '0; alrm_cmp_i = '0; alrm_per_i = '0; alrm_mode_i = 1'b0;
        alrm_arm_i = 1'b0; ie_i = '0; ista_clr_i = '0;
`ifdef RTC_CAPTURE_EN
        cap_trg_i = 1'b0;
`endif
        clk1(); clk1();
        checks++; if (cnt_o !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%0h exp=0", cnt_o); end
        checks++; if (ista_o !== '0) begin failures++; $display("FAIL reset_ista got=%0h exp=0", ista_o); end
        checks++; if (alrm_armed_o !== 4'b0000) begin failures++; $display("FAIL reset_armed got=%0h exp=0", alrm_armed_o); end
        checks++; if ({tick_o, irq_o} !== 2'b00) begin failures++; $display("FAIL reset_tick_irq got=%b exp=00", {tick_o, irq_o}); end
        rst_i = 1'b0;
        clk1();
    endtask

    task automatic test_prescaler();
        en_i = 1'b1; pscr_wr_i = 1'b1; pscr_i = 20'd3;
        clk1();
        pscr_wr_i = 1'b0;
        #1;
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (tick_o !== ((i % 4) == 3)) begin failures++; $display("FAIL psc_tick i=%0d got=%b exp=%b", i, tick_o, (i % 4) == 3); end
            clk1();
            checks++;
            if (cnt_o !== CW'((i + 1) / 4)) begin failures++; $display("FAIL psc_cnt i=%0d got=%0d exp=%0d", i, cnt_o, (i + 1) / 4); end
        end
        checks++; if (ista_o[TCK] !== 1'b1) begin failures++; $display("FAIL tick_flag_set got=%b exp=1", ista_o[TCK]); end
        ista_clr_i = '0; ista_clr_i[TCK] = 1'b1;
        clk1();
        ista_clr_i = '0;
        checks++; if (ista_o[TCK] !== 1'b0) begin failures++; $display("FAIL tick_flag_clr got=%b exp=0", ista_o[TCK]); end
    endtask

    task automatic test_overflow();
        logic [IW-1:0] exp;
        en_i = 1'b1; pscr_wr_i = 1'b1; pscr_i = '0; cnt_wr_i = 1'b1; cnt_wdata_i = 32'hFFFF_FFFE;
        ie_i = '1; ista_clr_i = '1;
        clk1();
        pscr_wr_i = 1'b0; cnt_wr_i = 1'b0; ista_clr_i = '0;
        checks++; if (ista_o !== '0) begin failures++; $display("FAIL ovf_load_ista got=%0h exp=0", ista_o); end
        clk1(); clk1();
        exp = '0; exp[TCK] = 1'b1; exp[OVF] = 1'b1;
        checks++; if (cnt_o !== 32'd0) begin failures++; $display("FAIL ovf_wrap_cnt got=%0h exp=0", cnt_o); end
        checks++; if (ista_o !== exp) begin failures++; $display("FAIL ovf_flag got=%0h exp=%0h", ista_o, exp); end
        checks++; if (irq_o !== 1'b1) begin failures++; $display("FAIL ovf_irq got=%b exp=1", irq_o); end
        cnt_wr_i = 1'b1; cnt_wdata_i = 32'hFFFF_FFFF; ista_clr_i = '1;
        clk1();
        checks++; if ({ista_o, irq_o} !== '0) begin failures++; $display("FAIL ovf_clear_all got=%0h/%b exp=0/0", ista_o, irq_o); end
        cnt_wr_i = 1'b0; ista_clr_i = exp;
        clk1();
        checks++; if (ista_o !== exp) begin failures++; $display("FAIL set_beats_clr got=%0h exp=%0h", ista_o, exp); end
        ista_clr_i = '0; ista_clr_i[OVF] = 1'b1;
        clk1();
        ista_clr_i = '0;
        exp = '0; exp[TCK] = 1'b1;
        checks++; if (ista_o !== exp) begin failures++; $display("FAIL ovf_w1c got=%0h exp=%0h", ista_o, exp); end
        checks++; if (cnt_o !== 32'd1) begin failures++; $display("FAIL ovf_post_cnt got=%0h exp=1", cnt_o); end
    endtask

    task automatic test_alarms();
        logic [IW-1:0] exp;
        logic [AN-1:0] exp_arm;
        en_i = 1'b0; cnt_wr_i = 1'b1; cnt_wdata_i = '0; ista_clr_i = '1;
        clk1();
        cnt_wr_i = 1'b0;
        alrm_write(0, 10, 0, 1'b0, 1'b1);
        clk1();
        alrm_write(1, 5, 5, 1'b1, 1'b1);
        clk1();
        alrm_wr_i = 1'b0;
        checks++; if (alrm_armed_o !== 4'b0011) begin failures++; $display("FAIL alrm_armed_init got=%b exp=0011", alrm_armed_o); end
        en_i = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            clk1();
            exp = '0; exp[TCK] = 1'b1; exp[0] = (n == 10); exp[1] = ((n % 5) == 0);
            exp_arm = {2'b00, 1'b1, (n < 10)};
            checks++;
            if ({cnt_o, ista_o, alrm_armed_o} !== {CW'(n), exp, exp_arm}) begin
                failures++;
                $display("FAIL alrm_seq n=%0d got cnt=%0d ista=%0h armed=%b exp cnt=%0d ista=%0h armed=%b",
                         n, cnt_o, ista_o, alrm_armed_o, n, exp, exp_arm);
            end
        end
        en_i = 1'b0; ista_clr_i = '0;
    endtask

    task automatic test_load_no_match();
        logic [IW-1:0] exp;
        alrm_write(1, 0, 0, 1'b0, 1'b0);
        clk1();
        alrm_write(2, 10, 0, 1'b0, 1'b1);
        clk1();
        alrm_wr_i = 1'b0;
        en_i = 1'b1; cnt_wr_i = 1'b1; cnt_wdata_i = 32'd10; ista_clr_i = '1;
        clk1();
        checks++; if ({cnt_o, ista_o} !== {32'd10, {IW{1'b0}}}) begin failures++; $display("FAIL load_no_match cnt=%0d ista=%0h exp 10/0", cnt_o, ista_o); end
        cnt_wr_i = 1'b0; ista_clr_i = '0;
        clk1();
        exp = '0; exp[TCK] = 1'b1;
        checks++; if ({cnt_o, ista_o} !== {32'd11, exp}) begin failures++; $display("FAIL load_next_tick cnt=%0d ista=%0h exp 11/%0h", cnt_o, ista_o, exp); end
        checks++; if (alrm_armed_o !== 4'b0100) begin failures++; $display("FAIL load_armed got=%b exp=0100", alrm_armed_o); end
    endtask

    task automatic test_wr_vs_match();
        logic [IW-1:0] exp;
        en_i = 1'b0; cnt_wr_i = 1'b1; cnt_wdata_i = 32'd20;
        alrm_write(3, 21, 100, 1'b1, 1'b1);
        clk1();
        cnt_wr_i = 1'b0; en_i = 1'b1; ista_clr_i = '1;
        alrm_write(3, 50, 0, 1'b0, 1'b1);
        clk1();
        alrm_wr_i = 1'b0;
        exp = '0; exp[TCK] = 1'b1; exp[3] = 1'b1;
        checks++; if ({cnt_o, ista_o} !== {32'd21, exp}) begin failures++; $display("FAIL wr_match_flag cnt=%0d ista=%0h exp 21/%0h", cnt_o, ista_o, exp); end
        checks++; if (alrm_armed_o !== 4'b1100) begin failures++; $display("FAIL wr_match_armed got=%b exp=1100", alrm_armed_o); end
        cnt_wr_i = 1'b1; cnt_wdata_i = 32'd48;
        clk1();
        cnt_wr_i = 1'b0;
        clk1();
        exp = '0; exp[TCK] = 1'b1;
        checks++; if ({cnt_o, ista_o} !== {32'd49, exp}) begin failures++; $display("FAIL wr_won_49 cnt=%0d ista=%0h exp 49/%0h", cnt_o, ista_o, exp); end
        clk1();
        exp[3] = 1'b1;
        checks++; if ({cnt_o, ista_o, alrm_armed_o} !== {32'd50, exp, 4'b0100}) begin
            failures++; $display("FAIL wr_won_50 cnt=%0d ista=%0h armed=%b exp 50/%0h/0100", cnt_o, ista_o, alrm_armed_o, exp);
        end
        ista_clr_i = '0;
    endtask

    task automatic test_pscr_write();
        logic [CW-1:0] c0;
        en_i = 1'b1; pscr_wr_i = 1'b1; pscr_i = 20'd3;
        clk1();
        pscr_wr_i = 1'b0;
        c0 = cnt_o;
        clk1(); clk1(); clk1();
        checks++; if (tick_o !== 1'b1) begin failures++; $display("FAIL pscr_pre_tick got=%b exp=1", tick_o); end
        pscr_wr_i = 1'b1; pscr_i = 20'd2;
        #1;
        checks++; if (tick_o !== 1'b0) begin failures++; $display("FAIL pscr_wr_suppress got=%b exp=0", tick_o); end
        clk1();
        pscr_wr_i = 1'b0;
        #1;
        checks++; if (cnt_o !== c0) begin failures++; $display("FAIL pscr_wr_cnt got=%0d exp=%0d", cnt_o, c0); end
        for (int j = 0; j < 3; j++) begin
            checks++; if (tick_o !== (j == 2)) begin failures++; $display("FAIL pscr_new_tick j=%0d got=%b exp=%b", j, tick_o, j == 2); end
            clk1();
        end
        checks++; if (cnt_o !== c0 + 32'd1) begin failures++; $display("FAIL pscr_new_cnt got=%0d exp=%0d", cnt_o, c0 + 32'd1); end
        en_i = 1'b0;
        for (int j = 0; j < 20; j++) begin
            #1;
            checks++; if (tick_o !== 1'b0) begin failures++; $display("FAIL freeze_tick j=%0d got=%b exp=0", j, tick_o); end
            clk1();
        end
        checks++; if (cnt_o !== c0 + 32'd1) begin failures++; $display("FAIL freeze_cnt got=%0d exp=%0d", cnt_o, c0 + 32'd1); end
        en_i = 1'b1;
        #1;
        for (int j = 0; j < 3; j++) begin
            checks++; if (tick_o !== (j == 2)) begin failures++; $display("FAIL resume_tick j=%0d got=%b exp=%b", j, tick_o, j == 2); end
            clk1();
        end
        checks++; if (cnt_o !== c0 + 32'd2) begin failures++; $display("FAIL resume_cnt got=%0d exp=%0d", cnt_o, c0 + 32'd2); end
    endtask

`ifdef RTC_CAPTURE_EN
    task automatic test_capture();
        en_i = 1'b0; cnt_wr_i = 1'b1; cnt_wdata_i = 32'd7; ista_clr_i = '1;
        clk1();
        cnt_wr_i = 1'b0; ista_clr_i = '0; cap_trg_i = 1'b1;
        clk1();
        checks++; if ({cap_o, ista_o[AN+2]} !== {32'd7, 1'b1}) begin failures++; $display("FAIL cap_latch got=%0d/%b exp=7/1", cap_o, ista_o[AN+2]); end
        en_i = 1'b1; ista_clr_i[AN+2] = 1'b1;
        clk1();
        ista_clr_i = '0;
        clk1(); clk1();
        checks++; if ({cap_o, ista_o[AN+2]} !== {32'd7, 1'b0}) begin failures++; $display("FAIL cap_held got=%0d/%b exp=7/0", cap_o, ista_o[AN+2]); end
        cap_trg_i = 1'b0;
    endtask
`endif

    task automatic test_async_reset();
        en_i = 1'b1;
        @(posedge clk_i);
        #2;
        rst_i = 1'b1; en_i = 1'b0;
        #1;
        checks++; if ({cnt_o, ista_o, alrm_armed_o, tick_o} !== '0) begin
            failures++; $display("FAIL async_reset cnt=%0h ista=%0h armed=%b tick=%b exp all 0", cnt_o, ista_o, alrm_armed_o, tick_o);
        end
        clk1();
        rst_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_prescaler();
        test_overflow();
        test_alarms();
        test_load_no_match();
        test_wr_vs_match();
        test_pscr_write();
`ifdef RTC_CAPTURE_EN
        test_capture();
`endif
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
